// File: rtl/pixel_concat_pkg.sv
// pixel_concat shared defaults: word width, group size, derived widths.
package pixel_concat_pkg;
  localparam int DAT_WIDTH  = 32;
  localparam int PIX_NUM    = 4;
  localparam int CNT_WIDTH  = $clog2(PIX_NUM);
  localparam int ODAT_WIDTH = DAT_WIDTH * PIX_NUM;
endpackage

// File: rtl/pixel_concat_if.sv
// Valid/stall stream bundle; master drives dat/val, slave drives stall.
interface pixel_concat_if #(
  parameter int W = 32
);
  logic [W-1:0] dat;
  logic         val;
  logic         stall;

  modport master (output dat, output val, input stall);
  modport slave  (input dat, input val, output stall);
endinterface

// File: rtl/pixel_concat_skid.sv
// One-entry skid register for the word in flight when ostall rises.
module pixel_concat_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fill_i,
  input  logic         drain_i,
  input  logic [W-1:0] dat_i,
  output logic [W-1:0] dat_o,
  output logic         full_o
);
  logic [W-1:0] dat_q, dat_d;
  logic         full_q, full_d;

  always_comb begin
    dat_d  = dat_q;
    full_d = full_q;
    if (fill_i) begin
      dat_d  = dat_i;
      full_d = 1'b1;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dat_q  <= '0;
      full_q <= 1'b0;
    end else begin
      dat_q  <= dat_d;
      full_q <= full_d;
    end
  end

  assign dat_o  = dat_q;
  assign full_o = full_q;
endmodule

// File: rtl/pixel_concat.sv
// Packs PIX_NUM pixel words into one wide group with skid-backed stall.
// Define PIXEL_CONCAT_MSB_FIRST_EN to place the first word in the top slice.
module pixel_concat #(
  parameter int DAT_WIDTH = pixel_concat_pkg::DAT_WIDTH,
  parameter int PIX_NUM   = pixel_concat_pkg::PIX_NUM
) (
  input  logic           clk,
  input  logic           rst,
  pixel_concat_if.slave  pix_i,
  pixel_concat_if.master grp_o
);
  localparam int CW = $clog2(PIX_NUM);
  localparam int OW = DAT_WIDTH * PIX_NUM;
  localparam logic [CW-1:0] LAST = CW'(PIX_NUM - 1);

  function automatic int slot(input int i);
`ifdef PIXEL_CONCAT_MSB_FIRST_EN
    return PIX_NUM - 1 - i;
`else
    return i;
`endif
  endfunction

  logic [PIX_NUM-2:0][DAT_WIDTH-1:0] asm_q, asm_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OW-1:0]        odat_q, odat_d, grp;
  logic                 oval_q, oval_d;
  logic                 skid_full;
  logic [DAT_WIDTH-1:0] skid_dat, src_dat;
  logic                 obuf_free, blocked;
  logic                 src_val, take, fill, drain;

  assign obuf_free   = !oval_q || !grp_o.stall;
  assign blocked     = (cnt_q == LAST) && !obuf_free;
  assign pix_i.stall = skid_full || blocked;

  // The skid word is always older than idat, so it wins.
  assign src_val = skid_full || pix_i.val;
  assign src_dat = skid_full ? skid_dat : pix_i.dat;
  assign take    = src_val && !blocked;
  assign fill    = pix_i.val && blocked;
  assign drain   = skid_full && !blocked;

  pixel_concat_skid #(
    .W(DAT_WIDTH)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .fill_i (fill),
    .drain_i(drain),
    .dat_i  (pix_i.dat),
    .dat_o  (skid_dat),
    .full_o (skid_full)
  );

  always_comb begin
    grp = '0;
    for (int i = 0; i < PIX_NUM - 1; i++) begin
      grp[slot(i)*DAT_WIDTH +: DAT_WIDTH] = asm_q[i];
    end
    grp[slot(PIX_NUM-1)*DAT_WIDTH +: DAT_WIDTH] = src_dat;
  end

  always_comb begin
    asm_d  = asm_q;
    cnt_d  = cnt_q;
    odat_d = odat_q;
    oval_d = oval_q;
    if (oval_q && !grp_o.stall) begin
      oval_d = 1'b0;
    end
    if (take && cnt_q != LAST) begin
      for (int i = 0; i < PIX_NUM - 1; i++) begin
        if (cnt_q == CW'(i)) asm_d[i] = src_dat;
      end
      cnt_d = cnt_q + 1'b1;
    end else if (take) begin
      odat_d = grp;
      oval_d = 1'b1;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q  <= '0;
      cnt_q  <= '0;
      odat_q <= '0;
      oval_q <= 1'b0;
    end else begin
      asm_q  <= asm_d;
      cnt_q  <= cnt_d;
      odat_q <= odat_d;
      oval_q <= oval_d;
    end
  end

  assign grp_o.dat = odat_q;
  assign grp_o.val = oval_q;
endmodule
